// File: rtl/inst_image_encoder_if.sv
// Request/write bundle for inst_image_encoder: symbolic instruction requests in,
// instruction-memory write strobes out.
interface inst_image_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        req_last;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;

    modport master (
        output req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2,
               req_imm, req_last,
        input  req_ready, mem_wr_en, mem_addr, mem_wr_data
    );

    modport slave (
        input  req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2,
               req_imm, req_last,
        output req_ready, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/inst_image_encoder.sv
// Packs symbolic RV32I requests into instruction words and writes them sequentially
// from BASE_ADDR. Define ENCODER_IMM_CHECK_EN to add the immediate range check and imm_err.
module inst_image_encoder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_image_encoder_if.slave   bus,
    output logic [ADDR_WIDTH:0]   inst_count,
    output logic                  done,
    output logic                  overflow
`ifdef ENCODER_IMM_CHECK_EN
    ,
    output logic                  imm_err
`endif
);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = CW'(DEPTH - 1);

    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_I      = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;
    localparam logic [2:0] KIND_JALR   = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [31:0] ECALL_WORD = 32'h00000073;

    typedef enum logic [1:0] {ACCEPT, WRITE, DONE, FULL} state_t;

    state_t      state;
    logic [31:0] next_addr;
    logic        last_q;
    logic [31:0] enc_word;
    logic [31:0] imm;
    logic        handshake;
    logic        unused_imm_bits;

    assign imm             = bus.req_imm;
    assign handshake       = bus.req_valid && bus.req_ready;
    assign unused_imm_bits = ^imm[31:21];

    // Shift immediates (funct3 001/101) carry funct7 in the upper immediate bits.
    always_comb begin
        enc_word = ECALL_WORD;
        case (bus.req_kind)
            KIND_R:      enc_word = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                                     bus.req_rd, OP_R};
            KIND_I: begin
                if (bus.req_funct3 == 3'b001 || bus.req_funct3 == 3'b101)
                    enc_word = {bus.req_funct7, imm[4:0], bus.req_rs1, bus.req_funct3,
                                bus.req_rd, OP_I};
                else
                    enc_word = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_I};
            end
            KIND_LOAD:   enc_word = {imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OP_LOAD};
            KIND_STORE:  enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010, imm[4:0],
                                     OP_STORE};
            KIND_BRANCH: enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1,
                                     bus.req_funct3, imm[4:1], imm[11], OP_BRANCH};
            KIND_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, OP_JAL};
            KIND_JALR:   enc_word = {imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OP_JALR};
            default:     enc_word = ECALL_WORD;
        endcase
    end

`ifdef ENCODER_IMM_CHECK_EN
    logic signed [31:0] simm;
    logic               imm_bad;
    assign simm = bus.req_imm;

    always_comb begin
        imm_bad = 1'b0;
        case (bus.req_kind)
            KIND_I, KIND_LOAD, KIND_STORE, KIND_JALR:
                imm_bad = (simm < -2048) || (simm > 2047);
            KIND_BRANCH:
                imm_bad = (simm < -4096) || (simm > 4094) || imm[0];
            KIND_JAL:
                imm_bad = (simm < -1048576) || (simm > 1048574) || imm[0];
            default: imm_bad = 1'b0;
        endcase
    end
`endif

    // A rejected immediate consumes the request without touching address or count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ACCEPT;
            bus.req_ready   <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
            next_addr       <= BASE_ADDR;
            inst_count      <= '0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            last_q          <= 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
            imm_err         <= 1'b0;
`endif
        end else begin
            bus.mem_wr_en <= 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
            imm_err       <= 1'b0;
`endif
            case (state)
                ACCEPT: begin
                    if (handshake) begin
                        last_q        <= bus.req_last;
                        bus.req_ready <= 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
                        if (imm_bad) begin
                            imm_err <= 1'b1;
                            if (bus.req_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                bus.req_ready <= 1'b1;
                            end
                        end else begin
`else
                        begin
`endif
                            state           <= WRITE;
                            bus.mem_wr_en   <= 1'b1;
                            bus.mem_addr    <= next_addr;
                            bus.mem_wr_data <= enc_word;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    next_addr  <= next_addr + 32'd4;
                    inst_count <= inst_count + 1'b1;
                    if (last_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (inst_count == LAST_SLOT) begin
                        state    <= FULL;
                        overflow <= 1'b1;
                    end else begin
                        state         <= ACCEPT;
                        bus.req_ready <= 1'b1;
                    end
                end
                DONE:    bus.req_ready <= 1'b0;
                FULL:    bus.req_ready <= 1'b0;
                default: state <= ACCEPT;
            endcase
        end
    end
endmodule
